// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner.
// The master side drives raw levels; the slave side returns the conditioned signals.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_repeat);
  modport slave  (input btn_raw, output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/button_conditioner.sv
// Per-channel push-button conditioner: 2-flop synchronizer, counter debounce,
// registered press/release pulses and an optional hold-to-repeat state machine.
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clock,
  input  logic                reset,
  button_conditioner_if.slave btn
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_REPEATING  = 2'd2
  } rpt_state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          release_q;
    logic          repeat_q;
    logic          flip_s;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic [RW-1:0] rpt_cnt_q;
    rpt_state_e    rpt_state_q;

    // Debounce: the level flips only on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
      flip_s    = 1'b0;
      deb_cnt_d = '0;
      if (sync2_q == level_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        flip_s    = 1'b1;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
      level_d = level_q ^ flip_s;
    end

    // Synchronizer, debounce state, edge pulses and repeat FSM; all outputs registered.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        deb_cnt_q   <= '0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        repeat_q    <= 1'b0;
        rpt_cnt_q   <= '0;
        rpt_state_q <= ST_IDLE;
      end else begin
        sync1_q   <= btn.btn_raw[i];
        sync2_q   <= sync1_q;
        deb_cnt_q <= deb_cnt_d;
        level_q   <= level_d;
        press_q   <= flip_s & ~level_q;
        release_q <= flip_s & level_q;
        repeat_q  <= 1'b0;
        // Release wins over a repeat pulse falling due on the same edge.
        if ((REPEAT_EN == 0) || !level_d) begin
          rpt_state_q <= ST_IDLE;
          rpt_cnt_q   <= '0;
        end else begin
          case (rpt_state_q)
            ST_IDLE: begin
              rpt_cnt_q   <= '0;
              rpt_state_q <= flip_s ? ST_WAIT_FIRST : ST_IDLE;
            end
            ST_WAIT_FIRST: begin
              if (rpt_cnt_q == DELAY_LAST) begin
                repeat_q    <= 1'b1;
                rpt_cnt_q   <= '0;
                rpt_state_q <= ST_REPEATING;
              end else begin
                rpt_cnt_q   <= rpt_cnt_q + RW'(1);
              end
            end
            ST_REPEATING: begin
              if (rpt_cnt_q == PERIOD_LAST) begin
                repeat_q  <= 1'b1;
                rpt_cnt_q <= '0;
              end else begin
                rpt_cnt_q <= rpt_cnt_q + RW'(1);
              end
            end
            default: begin
              rpt_cnt_q   <= '0;
              rpt_state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign btn.btn_level[i]   = level_q;
    assign btn.btn_press[i]   = press_q;
    assign btn.btn_release[i] = release_q;
    assign btn.btn_repeat[i]  = repeat_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a repeat-enabled and a repeat-disabled instance share stimulus;
// a window-based reference feeds a per-cycle scoreboard, table rows check pulse counts per segment.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;
  localparam int HW   = DEB + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  button_conditioner_if #(.N_BTN(2)) bus_r ();
  button_conditioner_if #(.N_BTN(2)) bus_n ();

  button_conditioner #(.N_BTN(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
                       .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER))
    dut_r (.clock(clock), .reset(reset), .btn(bus_r));
  button_conditioner #(.N_BTN(2), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
                       .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER))
    dut_n (.clock(clock), .reset(reset), .btn(bus_n));

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] rep;
  } obs_t;

  typedef struct {
    logic [1:0] raw;
    int         cyc;
    logic [1:0] lvl;
    int         prs0, prs1, rel0, rel1, rep0, rep1;
  } vec_t;

  obs_t       sb_q[$];
  vec_t       tbl[14];
  int         checks = 0;
  int         errors = 0;
  logic [HW-1:0] m_hist [2];
  logic [1:0] m_lvl;
  logic [1:0] m_act;
  int         m_since [2];
  int         n_prs [2];
  int         n_rel [2];
  int         n_rep [2];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference: level flips once the raw samples 2..DEB+1 edges old all disagree with it.
  task automatic model_step(input logic [1:0] raw, input logic rst, output obs_t e);
    logic win_all;
    logic rose;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_hist[c]  = '0;
        m_lvl[c]   = 1'b0;
        m_act[c]   = 1'b0;
        m_since[c] = 0;
      end else begin
        m_hist[c] = {m_hist[c][HW-2:0], raw[c]};
        win_all   = (m_hist[c][HW-1:2] == {DEB{~m_lvl[c]}});
        rose      = 1'b0;
        if (win_all) begin
          m_lvl[c] = ~m_lvl[c];
          e.prs[c] = m_lvl[c];
          e.rel[c] = ~m_lvl[c];
          rose     = m_lvl[c];
        end
        if (rose) begin
          m_act[c]   = 1'b1;
          m_since[c] = 0;
        end else if (m_act[c]) begin
          m_since[c]++;
        end
        if (!m_lvl[c]) m_act[c] = 1'b0;
        e.rep[c] = m_act[c] && !rose && (m_since[c] >= RDLY) &&
                   (((m_since[c] - RDLY) % RPER) == 0);
        e.lvl[c] = m_lvl[c];
      end
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      n_prs[c] = 0;
      n_rel[c] = 0;
      n_rep[c] = 0;
    end
  endtask

  task automatic step(input logic [1:0] raw, input logic rst);
    obs_t e, got_r, got_n, exp_n;
    bus_r.btn_raw = raw;
    bus_n.btn_raw = raw;
    reset = rst;
    model_step(raw, rst, e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e     = sb_q.pop_front();
    got_r = {bus_r.btn_level, bus_r.btn_press, bus_r.btn_release, bus_r.btn_repeat};
    got_n = {bus_n.btn_level, bus_n.btn_press, bus_n.btn_release, bus_n.btn_repeat};
    exp_n = e;
    exp_n.rep = 2'b00;
    check("cycle_outputs_repeat_on", 32'(got_r), 32'(e));
    check("cycle_outputs_repeat_off", 32'(got_n), 32'(exp_n));
    for (int c = 0; c < 2; c++) begin
      n_prs[c] += int'(got_r.prs[c]);
      n_rel[c] += int'(got_r.rel[c]);
      n_rep[c] += int'(got_r.rep[c]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int press_at;
    //          raw    cyc  lvl    p0 p1 r0 r1 q0 q1
    tbl[0]  = '{2'b00, 8,  2'b00, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b01, 8,  2'b01, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{2'b00, 8,  2'b00, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{2'b01, 3,  2'b00, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{2'b00, 3,  2'b00, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{2'b01, 3,  2'b00, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{2'b00, 3,  2'b00, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{2'b01, 6,  2'b01, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{2'b01, 28, 2'b01, 0, 0, 0, 0, 7, 0};
    tbl[9]  = '{2'b00, 8,  2'b00, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{2'b11, 8,  2'b11, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{2'b01, 8,  2'b01, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{2'b00, 8,  2'b00, 0, 0, 1, 0, 1, 0};
    tbl[13] = '{2'b01, 7,  2'b01, 1, 0, 0, 0, 0, 0};

    bus_r.btn_raw = 2'b00;
    bus_n.btn_raw = 2'b00;
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    check("reset_state",
          32'({bus_r.btn_level, bus_r.btn_press, bus_r.btn_release, bus_r.btn_repeat,
               bus_n.btn_level, bus_n.btn_press, bus_n.btn_release, bus_n.btn_repeat}), 0);

    for (int r = 0; r < 14; r++) begin
      clear_counts();
      for (int k = 0; k < tbl[r].cyc; k++) step(tbl[r].raw, 1'b0);
      check($sformatf("row%0d_level", r), 32'(bus_r.btn_level), 32'(tbl[r].lvl));
      check($sformatf("row%0d_press0", r), n_prs[0], tbl[r].prs0);
      check($sformatf("row%0d_press1", r), n_prs[1], tbl[r].prs1);
      check($sformatf("row%0d_release0", r), n_rel[0], tbl[r].rel0);
      check($sformatf("row%0d_release1", r), n_rel[1], tbl[r].rel1);
      check($sformatf("row%0d_repeat0", r), n_rep[0], tbl[r].rep0);
      check($sformatf("row%0d_repeat1", r), n_rep[1], tbl[r].rep1);
    end

    // Reset while channel 0 is held: everything clears silently, then a fresh press follows.
    clear_counts();
    step(2'b01, 1'b1);
    check("reset_mid_hold_clear",
          32'({bus_r.btn_level, bus_r.btn_press, bus_r.btn_release, bus_r.btn_repeat}), 0);
    press_at = -1;
    for (int k = 1; k <= 8; k++) begin
      step(2'b01, 1'b0);
      if (bus_r.btn_press[0] && (press_at < 0)) press_at = k;
    end
    check("reset_mid_hold_press_edge", press_at, 6);
    check("reset_mid_hold_press_count", n_prs[0], 1);
    check("reset_mid_hold_no_release", n_rel[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-side counterpart to the display path. It takes raw, asynchronous push-button levels from the board (btnC, btnU, etc.) and turns them into clean, clock-domain signals:
- a debounced level per button;
- one-cycle press and release pulses;
- optional hold-to-repeat pulses.

It sits between the board pins and consumers such as the ALU doAction input, which must see exactly one pulse per physical press.

Parameters:
N_BTN, 2, number of independent button channels (>=1)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz; >=1)
REPEAT_EN, 0, 1 enables auto-repeat pulses while a button is held
REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse (>=1)
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (>=1)

Ports:
clock  input  1  system clock, single domain; all state updates on the rising edge
reset  input  1  synchronous, active-high; sampled on the rising edge of clock
btn_raw  input  N_BTN  raw, asynchronous, bouncing button levels (1 = pressed)
btn_level  output  N_BTN  debounced level per channel
btn_press  output  N_BTN  one-cycle pulse on each accepted 0->1 transition of btn_level
btn_release  output  N_BTN  one-cycle pulse on each accepted 1->0 transition of btn_level
btn_repeat  output  N_BTN  one-cycle auto-repeat pulses while held; constant 0 when REPEAT_EN=0

Behaviour:
- Reset: on a clock edge with reset=1, the following all clear to 0 for every channel:
  - synchronizer flops, debounce counters and repeat counters;
  - btn_level, btn_press, btn_release and btn_repeat.
- Synchronizer: a 2-flop synchronizer per channel gives sync[i]. sync[i] reflects btn_raw[i] two edges after the raw change.
- Debounce counter: one per channel, width $clog2(DEBOUNCE_CYCLES+1).
  - sync[i] == btn_level[i]: counter clears to 0.
  - sync[i] != btn_level[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync[i] != btn_level[i] and counter == DEBOUNCE_CYCLES-1: btn_level[i] toggles on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles (in the sync domain) is fully rejected; the counter restarts from 0 on every bounce.
- Latency: a clean raw step reaches btn_level after 2 + DEBOUNCE_CYCLES rising edges.
- Press/release pulses:
  - btn_press[i] is registered and high for exactly the one cycle after the edge on which btn_level[i] goes 0->1.
  - btn_release[i] is the same for the 1->0 transition.
  - The two are never high together.
  - Minimum spacing between press pulses is 2*DEBOUNCE_CYCLES cycles.
- Repeat state machine (per channel, only when REPEAT_EN=1). States: IDLE, WAIT_FIRST, REPEATING.
  - IDLE -> WAIT_FIRST: on the cycle btn_press[i]=1; repeat counter loads 0.
  - WAIT_FIRST: counter increments each cycle. At count REPEAT_DELAY-1: btn_repeat[i] pulses for one cycle, counter clears, go to REPEATING.
  - REPEATING: counter increments. At REPEAT_PERIOD-1: btn_repeat[i] pulses, counter clears, stay in REPEATING.
  - Any state -> IDLE: when btn_level[i]=0. Checked with priority over a pending repeat pulse, so no btn_repeat on the release cycle.
  - Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- btn_repeat and btn_press are never high in the same cycle.
- Channels are fully independent; simultaneous presses on several channels produce simultaneous pulses.
- Reset mid-operation: btn_level drops to 0 without a btn_release pulse. If the button is still held after reset deasserts, it is re-debounced and produces a fresh btn_press 2 + DEBOUNCE_CYCLES cycles later.
- No combinational path from btn_raw to any output.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: reset, then btn_raw[0] 0->1 held -> btn_level[0]=1 exactly 6 edges after the change; btn_press[0] high for 1 cycle; btn_press[1], btn_release and btn_repeat stay 0.
- Bounce rejection: btn_raw[0] toggles 1,0,1,0 with 3-cycle dwell, then holds 1 -> no output activity during bouncing; btn_level rises 6 edges after the final rise; exactly one btn_press.
- Release: from held, btn_raw[0] 1->0 held -> btn_level falls 6 edges later; exactly one btn_release pulse; no btn_press.
- Auto-repeat (REPEAT_EN=1): hold btn_raw[0] for 30 cycles after btn_press -> btn_repeat pulses at 10, 13, 16, 19, 22, 25, 28 cycles after the press pulse; release -> pulses stop and no repeat on the release cycle.
- Simultaneous channels: btn_raw = 2'b11 in one cycle -> btn_press = 2'b11 in the same cycle; then release only channel 1 -> btn_release = 2'b10, with btn_level[0] still 1.
- Reset mid-hold: assert reset for 1 cycle while btn_level[0]=1 and btn_raw[0]=1 -> all outputs 0 the next cycle with no btn_release; btn_press[0] pulses again 6 edges after reset deasserts.
